// File: rtl/systolic_skew_feeder_if.sv
// systolic_skew_feeder_if
//   Handshake and array-side bundle for systolic_skew_feeder.
//   master : job/stream source (drives START, LEN, IN_VALID, IN_DATA)
//   slave  : the feeder (drives IN_READY, ARR_*, BUSY, DONE)
//   START/LEN    job kick-off and vector count
//   IN_*         valid/ready activation stream, lane i = IN_DATA[i*WIDTH +: WIDTH]
//   ARR_DATA     skewed lanes to the array row inputs
//   ARR_EN       array-wide PE enable
//   ARR_CLR      array-wide accumulator clear
//   BUSY/DONE    job status
//   STALL_CNT    only present when SKEW_FEEDER_STALL_CNT_EN is defined
interface systolic_skew_feeder_if #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int LEN_W = 16
);
  logic                  START;
  logic [LEN_W-1:0]      LEN;
  logic                  IN_VALID;
  logic                  IN_READY;
  logic [ROWS*WIDTH-1:0] IN_DATA;
  logic [ROWS*WIDTH-1:0] ARR_DATA;
  logic                  ARR_EN;
  logic                  ARR_CLR;
  logic                  BUSY;
  logic                  DONE;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [LEN_W-1:0]      STALL_CNT;
`endif

  modport master (
    output START, LEN, IN_VALID, IN_DATA,
    input  IN_READY, ARR_DATA, ARR_EN, ARR_CLR, BUSY, DONE
`ifdef SKEW_FEEDER_STALL_CNT_EN
    , input STALL_CNT
`endif
  );

  modport slave (
    input  START, LEN, IN_VALID, IN_DATA,
    output IN_READY, ARR_DATA, ARR_EN, ARR_CLR, BUSY, DONE
`ifdef SKEW_FEEDER_STALL_CNT_EN
    , output STALL_CNT
`endif
  );
endinterface

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder
//   Left-edge feeder for a ROWS x COLS output-stationary PE array. Accepts one
//   ROWS-lane vector per handshake, skews lane i by i extra steps, drives the
//   array-wide EN/CLR strobes, flushes ROWS+COLS-2 zero steps so the last
//   vector crosses every column, and pulses DONE once all sums are final.
// Ports
//   CLK        clock
//   ASYNC_RST  asynchronous active-low reset
//   SYNC_RST   synchronous active-high clear (same effect as ASYNC_RST)
//   bus        systolic_skew_feeder_if.slave (job, stream and array signals)
// Build option
//   SKEW_FEEDER_STALL_CNT_EN : adds bus.STALL_CNT, a saturating count of FEED
//   cycles where the feeder was ready but no vector was offered.

// One lane of the skew: a DEPTH-deep shift chain advanced by adv.
module skew_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             CLK,
  input  logic             ASYNC_RST,
  input  logic             clr,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else if (adv) begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

module systolic_skew_feeder #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 16
) (
  input logic                   CLK,
  input logic                   ASYNC_RST,
  input logic                   SYNC_RST,
  systolic_skew_feeder_if.slave bus
);
  // Zero steps needed after the last vector so it reaches the far column.
  localparam int FL   = ROWS + COLS - 2;
  localparam int FL_W = (FL > 1) ? $clog2(FL) : 1;
  localparam logic [FL_W-1:0]  FL_LAST = FL_W'((FL > 0) ? FL - 1 : 0);
  localparam logic [FL_W-1:0]  FL_ONE  = FL_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t                      state;
  logic [LEN_W-1:0]            len_r;
  logic [LEN_W-1:0]            acc_cnt;
  logic [FL_W-1:0]             fl_cnt;
  logic                        arr_en;
  logic                        arr_clr;
  logic                        done;

  logic                        in_ready;
  logic                        accept;
  logic                        adv;
  logic                        start_acc;
  logic                        lane_clr;
  logic [ROWS-1:0][WIDTH-1:0]  lane_in;
  logic [ROWS-1:0][WIDTH-1:0]  lane_out;

  // acc_cnt never reaches len_r inside FEED (last accept leaves FEED), so
  // LEN = all-ones needs no extra counter bit.
  assign in_ready  = (state == FEED) && (acc_cnt < len_r);
  assign accept    = in_ready & bus.IN_VALID;
  assign adv       = accept | (state == FLUSH);
  assign start_acc = (state == IDLE) & bus.START;
  // Chains are also wiped at job start so no residue from an earlier job
  // can leak into a new one.
  assign lane_clr  = SYNC_RST | start_acc;
  assign lane_in   = (state == FEED) ? bus.IN_DATA : '0;

  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    skew_lane #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_lane (
      .CLK       (CLK),
      .ASYNC_RST (ASYNC_RST),
      .clr       (lane_clr),
      .adv       (adv),
      .din       (lane_in[i]),
      .dout      (lane_out[i])
    );
  end

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      state   <= IDLE;
      len_r   <= '0;
      acc_cnt <= '0;
      fl_cnt  <= '0;
      arr_en  <= 1'b0;
      arr_clr <= 1'b0;
      done    <= 1'b0;
    end else if (SYNC_RST) begin
      state   <= IDLE;
      len_r   <= '0;
      acc_cnt <= '0;
      fl_cnt  <= '0;
      arr_en  <= 1'b0;
      arr_clr <= 1'b0;
      done    <= 1'b0;
    end else begin
      // EN lags adv by one so it lines up with the freshly shifted data.
      arr_en  <= adv;
      arr_clr <= 1'b0;
      // DRAIN sits on the last EN cycle; DONE lands one cycle later.
      done    <= (state == DRAIN);
      case (state)
        IDLE: begin
          if (bus.START) begin
            len_r   <= bus.LEN;
            acc_cnt <= '0;
            fl_cnt  <= '0;
            arr_clr <= 1'b1;
            state   <= (bus.LEN != '0) ? FEED : DRAIN;
          end
        end
        FEED: begin
          if (accept) begin
            if (acc_cnt == len_r - LEN_ONE) begin
              fl_cnt <= '0;
              state  <= (FL == 0) ? DRAIN : FLUSH;
            end else begin
              acc_cnt <= acc_cnt + LEN_ONE;
            end
          end
        end
        FLUSH: begin
          if (fl_cnt == FL_LAST) state  <= DRAIN;
          else                   fl_cnt <= fl_cnt + FL_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.ARR_DATA = lane_out;
  assign bus.ARR_EN   = arr_en;
  assign bus.ARR_CLR  = arr_clr;
  assign bus.BUSY     = (state != IDLE);
  assign bus.DONE     = done;

`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [LEN_W-1:0] stall_cnt;

  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      stall_cnt <= '0;
    end else if (SYNC_RST || start_acc) begin
      stall_cnt <= '0;
    end else if (in_ready && !bus.IN_VALID && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + LEN_ONE;
    end
  end

  assign bus.STALL_CNT = stall_cnt;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder
//   Directed bench for systolic_skew_feeder (ROWS=4, COLS=4, WIDTH=8).
//   Each job is run cycle by cycle; the ARR_EN-qualified lane sequences,
//   strobe timing and counts are compared against hand-derived constants.
module tb_systolic_skew_feeder;
  localparam int W  = 8;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int LW = 16;

  logic clk = 1'b0;
  logic arst_n;
  logic srst;

  always #5 clk = ~clk;

  systolic_skew_feeder_if #(.WIDTH(W), .ROWS(R), .LEN_W(LW)) bus ();

  systolic_skew_feeder #(.WIDTH(W), .ROWS(R), .COLS(C), .LEN_W(LW)) dut (
    .CLK       (clk),
    .ASYNC_RST (arst_n),
    .SYNC_RST  (srst),
    .bus       (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  // per-job capture
  int           en_cnt, clr_cnt, clr_cyc, rdy_seen, done_cnt, done_cyc;
  int           first_en, last_en, low_gaps, hold_bad, overlap;
  logic [127:0] seq [R];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [R*W-1:0] vec(input int k);
    logic [R*W-1:0] v;
    for (int i = 0; i < R; i++) v[i*W +: W] = W'(4*k + i + 1);
    return v;
  endfunction

  // Runs one job. gap_n: cycles IN_VALID is dropped after the first accept.
  // restart: pulse START (with a different LEN) while BUSY.
  task automatic run_job(input logic [LW-1:0] len, input int gap_n, input bit restart);
    int k;
    int cyc;
    int gap_left;
    logic [R*W-1:0] prev;
    k = 0; gap_left = gap_n; prev = '0;
    en_cnt = 0; clr_cnt = 0; clr_cyc = -1; rdy_seen = 0; done_cnt = 0; done_cyc = -1;
    first_en = -1; last_en = -1; low_gaps = 0; hold_bad = 0; overlap = 0;
    for (int i = 0; i < R; i++) seq[i] = '0;
    bus.START = 1'b1; bus.LEN = len; bus.IN_VALID = 1'b0;
    step(); cyc = 1;
    bus.START = 1'b0;
    if (restart) bus.LEN = 16'd7;
    while (cyc < 300) begin
      if (bus.ARR_CLR) begin clr_cnt++; clr_cyc = cyc; end
      if (bus.ARR_CLR && bus.ARR_EN) overlap++;
      if (bus.IN_READY) rdy_seen++;
      if (bus.ARR_EN) begin
        if (first_en < 0) first_en = cyc;
        else if (cyc > last_en + 1) low_gaps += cyc - last_en - 1;
        en_cnt++; last_en = cyc;
        for (int i = 0; i < R; i++) seq[i] = {seq[i][127-W:0], bus.ARR_DATA[i*W +: W]};
      end else if (first_en >= 0 && bus.BUSY && bus.ARR_DATA !== prev) begin
        hold_bad++;
      end
      prev = bus.ARR_DATA;
      if (bus.DONE) begin done_cnt++; done_cyc = cyc; end
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      if (bus.IN_READY && !(k > 0 && gap_left > 0)) begin
        bus.IN_VALID = 1'b1; bus.IN_DATA = vec(k); k++;
      end else begin
        bus.IN_VALID = 1'b0;
        if (bus.IN_READY && k > 0 && gap_left > 0) gap_left--;
      end
      bus.START = restart && bus.BUSY && (cyc % 2 == 1);
      step(); cyc++;
    end
    bus.IN_VALID = 1'b0; bus.START = 1'b0;
  endtask

  initial begin
    int dn;
    arst_n = 1'b0; srst = 1'b0;
    bus.START = 1'b0; bus.LEN = '0; bus.IN_VALID = 1'b0; bus.IN_DATA = '0;
    #12;
    chk("rst_outs", {bus.ARR_EN, bus.ARR_CLR, bus.BUSY, bus.DONE, bus.IN_READY}, 5'b0);
    chk("rst_data", bus.ARR_DATA, '0);
`ifdef SKEW_FEEDER_STALL_CNT_EN
    chk("rst_stall", bus.STALL_CNT, '0);
`endif
    arst_n = 1'b1;
    step();

    // continuous LEN=3
    run_job(16'd3, 0, 1'b0);
    chk("a_clr_cnt", clr_cnt, 1);
    chk("a_clr_cyc", clr_cyc, 1);
    chk("a_first_en", first_en, 2);
    chk("a_en_cnt", en_cnt, 9);
    chk("a_low_gaps", low_gaps, 0);
    chk("a_done_cnt", done_cnt, 1);
    chk("a_done_cyc", done_cyc, last_en + 1);
    chk("a_done_abs", done_cyc, 11);
    chk("a_overlap", overlap, 0);
    chk("a_lane0", seq[0], 72'h010509000000000000);
    chk("a_lane1", seq[1], 72'h0002060A0000000000);
    chk("a_lane2", seq[2], 72'h000003070B00000000);
    chk("a_lane3", seq[3], 72'h00000004080C000000);

    // LEN=3 with two bubbles after the first accept
    run_job(16'd3, 2, 1'b0);
    chk("b_en_cnt", en_cnt, 9);
    chk("b_low_gaps", low_gaps, 2);
    chk("b_hold", hold_bad, 0);
    chk("b_done_cyc", done_cyc, 13);
    chk("b_done_cnt", done_cnt, 1);
    chk("b_lane0", seq[0], 72'h010509000000000000);
    chk("b_lane3", seq[3], 72'h00000004080C000000);
`ifdef SKEW_FEEDER_STALL_CNT_EN
    chk("b_stall", bus.STALL_CNT, 16'd2);
`endif

    // LEN=0
    run_job(16'd0, 0, 1'b0);
    chk("c_clr_cyc", clr_cyc, 1);
    chk("c_done_cyc", done_cyc, 2);
    chk("c_done_cnt", done_cnt, 1);
    chk("c_en_cnt", en_cnt, 0);
    chk("c_rdy", rdy_seen, 0);

    // SYNC_RST after two accepts of LEN=5
    bus.START = 1'b1; bus.LEN = 16'd5;
    step();
    bus.START = 1'b0;
    bus.IN_VALID = 1'b1; bus.IN_DATA = vec(0); step();
    bus.IN_DATA = vec(1); step();
    chk("s_pre_busy", bus.BUSY, 1'b1);
    srst = 1'b1; bus.IN_VALID = 1'b0;
    step();
    srst = 1'b0;
    chk("s_outs", {bus.ARR_EN, bus.ARR_CLR, bus.BUSY, bus.DONE, bus.IN_READY}, 5'b0);
    chk("s_data", bus.ARR_DATA, '0);
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.DONE) dn++;
      step();
    end
    chk("s_no_done", dn, 0);

    // fresh LEN=1 job after the abort
    run_job(16'd1, 0, 1'b0);
    chk("d_en_cnt", en_cnt, 7);
    chk("d_done_cyc", done_cyc, 9);
    chk("d_done_cnt", done_cnt, 1);
    chk("d_lane0", seq[0], 56'h01000000000000);
    chk("d_lane3", seq[3], 56'h00000004000000);

    // START pulsed while BUSY must be ignored
    run_job(16'd2, 0, 1'b1);
    chk("e_en_cnt", en_cnt, 8);
    chk("e_done_cyc", done_cyc, 10);
    chk("e_done_cnt", done_cnt, 1);
    chk("e_lane0", seq[0], 64'h0105000000000000);
    chk("e_lane3", seq[3], 64'h0000000408000000);

    // LEN all-ones: still feeding after a few accepts, then async reset mid-cycle
    bus.START = 1'b1; bus.LEN = 16'hFFFF;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.IN_VALID = 1'b1; bus.IN_DATA = vec(i); step();
    end
    bus.IN_VALID = 1'b0;
    chk("f_ready", bus.IN_READY, 1'b1);
    chk("f_busy", bus.BUSY, 1'b1);
    chk("f_en", bus.ARR_EN, 1'b1);
    #2 arst_n = 1'b0;
    #1;
    chk("f_arst_outs", {bus.ARR_EN, bus.ARR_CLR, bus.BUSY, bus.DONE, bus.IN_READY}, 5'b0);
    chk("f_arst_data", bus.ARR_DATA, '0);
    #2 arst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
